// File: rtl/regbank_ctx_seq.sv
// -----------------------------------------------------------------------------
// regbank_ctx_seq
//
// Context-switch register sequencer. On a Start request it walks the general
// registers FIRST_REG..LAST_REG and either copies them from the register bank
// to process storage (save, Dir=0) or from process storage back into the bank
// (restore, Dir=1). While Busy is high this block owns the bank's read index,
// write index, write data and write strobe; the CPU control unit stalls the
// pipeline on Busy.
//
// Handshake with storage: a request (MemWrite or MemRead) is held, together
// with a stable MemAddr (and MemWData for writes), until the cycle in which
// MemReady is sampled high on a rising CLK edge. That edge completes the
// request. MemReady may already be high in the first request cycle. MemReady
// seen in any other state is ignored.
//
// Ports:
//   CLK       in   system clock, all state changes on the rising edge
//   Reset     in   asynchronous, active-low reset
//   Start     in   one-cycle request, sampled only in IDLE
//   Dir       in   0 = save (bank -> storage), 1 = restore (storage -> bank)
//   BaseAddr  in   storage word address of the FIRST_REG slot
//   Abort     in   terminates the current transfer (ignored in IDLE and FIN)
//   RegSel    out  bank read index (RegLeit1)
//   RegData   in   bank read data, valid one CLK after RegSel is stable
//   RegWIdx   out  bank write index (RegEscrita)
//   RegWData  out  bank write data (DadoEscrita)
//   RegWrite  out  bank write strobe, one cycle per restored register
//   MemAddr   out  storage word address = BaseAddr + (idx - FIRST_REG), wraps
//   MemWData  out  storage write data
//   MemWrite  out  storage write request, held until MemReady
//   MemRead   out  storage read request, held until MemReady
//   MemRData  in   storage read data, valid with MemReady
//   MemReady  in   storage completion for the current request
//   Busy      out  high in every state except IDLE
//   Done      out  one-cycle pulse (the FIN state) on normal completion
//   Err       out  one-cycle pulse, in the first IDLE cycle after an Abort
//   DbgState  out  current FSM state encoding, for observation only
// -----------------------------------------------------------------------------
module regbank_ctx_seq #(
    parameter int FIRST_REG = 1,
    parameter int LAST_REG  = 31,
    parameter int ADDR_W    = 32
) (
    input  logic              CLK,
    input  logic              Reset,
    input  logic              Start,
    input  logic              Dir,
    input  logic [ADDR_W-1:0] BaseAddr,
    input  logic              Abort,
    output logic [4:0]        RegSel,
    input  logic [31:0]       RegData,
    output logic [4:0]        RegWIdx,
    output logic [31:0]       RegWData,
    output logic              RegWrite,
    output logic [ADDR_W-1:0] MemAddr,
    output logic [31:0]       MemWData,
    output logic              MemWrite,
    output logic              MemRead,
    input  logic [31:0]       MemRData,
    input  logic              MemReady,
    output logic              Busy,
    output logic              Done,
    output logic              Err,
    output logic [2:0]        DbgState
);

    // State encoding, kept as plain constants so the value on DbgState can be
    // decoded directly by anyone watching the bus.
    localparam logic [2:0] IDLE   = 3'd0;
    localparam logic [2:0] S_SEL  = 3'd1;
    localparam logic [2:0] S_WAIT = 3'd2;
    localparam logic [2:0] S_MEM  = 3'd3;
    localparam logic [2:0] R_MEM  = 3'd4;
    localparam logic [2:0] R_WR   = 3'd5;
    localparam logic [2:0] FIN    = 3'd6;

    localparam logic [4:0] FIRST_IDX = 5'(FIRST_REG);
    localparam logic [4:0] LAST_IDX  = 5'(LAST_REG);

    logic [2:0]        state;
    logic [2:0]        stateNext;
    logic [4:0]        idx;
    logic [4:0]        idxNext;
    logic [ADDR_W-1:0] baseQ;
    logic [31:0]       memWDataQ;
    logic [31:0]       regWDataQ;
    logic [4:0]        regWIdxQ;
    logic              errQ;
    logic              abortHit;
    logic              lastReg;
    logic [ADDR_W-1:0] slotOffset;

    // Abort only counts while a transfer is actually running. FIN is the
    // completion cycle itself, so an Abort there is too late and is dropped.
    assign abortHit = Abort && (state != IDLE) && (state != FIN);
    assign lastReg  = (idx == LAST_IDX);

    // idx never drops below FIRST_IDX, so the 5-bit difference is the slot
    // number; the add below is modulo 2^ADDR_W and wraps without complaint.
    assign slotOffset = ADDR_W'(idx - FIRST_IDX);

    // -------------------------------------------------------------------------
    // Next-state logic. The direction chosen at Start is carried by which
    // branch of the FSM is entered, so no separate direction flop is kept.
    // -------------------------------------------------------------------------
    always_comb begin
        stateNext = state;
        idxNext   = idx;
        case (state)
            IDLE: begin
                if (Start) begin
                    idxNext   = FIRST_IDX;
                    stateNext = Dir ? R_MEM : S_SEL;
                end
            end
            S_SEL: begin
                stateNext = S_WAIT;
            end
            S_WAIT: begin
                stateNext = S_MEM;
            end
            S_MEM: begin
                if (MemReady) begin
                    if (lastReg) begin
                        stateNext = FIN;
                    end else begin
                        idxNext   = idx + 5'd1;
                        stateNext = S_SEL;
                    end
                end
            end
            R_MEM: begin
                if (MemReady) begin
                    stateNext = R_WR;
                end
            end
            R_WR: begin
                if (lastReg) begin
                    stateNext = FIN;
                end else begin
                    idxNext   = idx + 5'd1;
                    stateNext = R_MEM;
                end
            end
            FIN: begin
                stateNext = IDLE;
            end
            default: begin
                stateNext = IDLE;
            end
        endcase

        // Abort overrides any advance, including one triggered by a MemReady
        // arriving in the same cycle.
        if (abortHit) begin
            stateNext = IDLE;
            idxNext   = FIRST_IDX;
        end
    end

    // -------------------------------------------------------------------------
    // State and datapath registers.
    // -------------------------------------------------------------------------
    always_ff @(posedge CLK or negedge Reset) begin
        if (!Reset) begin
            state     <= IDLE;
            idx       <= FIRST_IDX;
            baseQ     <= '0;
            memWDataQ <= '0;
            regWDataQ <= '0;
            regWIdxQ  <= '0;
            errQ      <= 1'b0;
        end else begin
            state <= stateNext;
            idx   <= idxNext;
            errQ  <= abortHit;

            if ((state == IDLE) && Start) begin
                baseQ <= BaseAddr;
            end

            // RegSel has been stable since S_SEL, so RegData is valid by the
            // end of S_WAIT.
            if ((state == S_WAIT) && !abortHit) begin
                memWDataQ <= RegData;
            end

            // A read completion that coincides with Abort is discarded.
            if ((state == R_MEM) && MemReady && !abortHit) begin
                regWDataQ <= MemRData;
                regWIdxQ  <= idx;
            end
        end
    end

    // -------------------------------------------------------------------------
    // Outputs. Everything is gated by state so that an asynchronous reset,
    // which forces state to IDLE, drops every strobe and address at once.
    // -------------------------------------------------------------------------
    assign RegSel   = ((state == S_SEL) || (state == S_WAIT)) ? idx : 5'd0;
    assign MemAddr  = ((state == S_MEM) || (state == R_MEM)) ? (baseQ + slotOffset) : '0;
    assign MemWData = memWDataQ;
    assign MemWrite = (state == S_MEM);
    assign MemRead  = (state == R_MEM);
    assign RegWIdx  = regWIdxQ;
    assign RegWData = regWDataQ;
    // Abort in R_WR cancels the write of that register as well.
    assign RegWrite = (state == R_WR) && !Abort;
    assign Busy     = (state != IDLE);
    assign Done     = (state == FIN);
    assign Err      = errQ;
    assign DbgState = state;

    // -------------------------------------------------------------------------
    // Simulation-only sanity checks: r0 is hard-wired and must never be
    // targeted, and the range parameters must describe a non-empty range.
    // -------------------------------------------------------------------------
    always @(posedge CLK) begin
        if (Reset) begin
            assert (FIRST_REG != 0)
                else $error("regbank_ctx_seq: FIRST_REG must not be 0");
            assert ((FIRST_REG <= LAST_REG) && (LAST_REG <= 31))
                else $error("regbank_ctx_seq: bad register range");
            assert (!(RegWrite && (RegWIdx == 5'd0)))
                else $error("regbank_ctx_seq: write to r0");
        end
    end

endmodule
